led_seq_ctrl: RTL and testbench
===============================

// Module: led_seq_ctrl
// PURPOSE
//  Sequencer for the board LED shift-register datapath. A prescaler derives a one-cycle step tick
//  from the system clock. A small FSM (IDLE/RUN/HOLD) applies a selectable pattern operation on each
//  tick: rotate left, rotate right, bounce or invert. Sits between top-level controls and the led pins;
//  single-step via 4-phase handshake while held.
// PARAMETERS
//  CLK_HZ   100_000_000  clock frequency in Hz
//  STEP_HZ  1            step rate; TICK_DIV = CLK_HZ/STEP_HZ (>=2), counter width $clog2(TICK_DIV)
//  LED_W    4            pattern/LED width (>=2)
//  PWM_BITS 4            PWM counter/duty width (LED_PWM_EN only)
// PORTS
//  clk         in   1         system clock, all logic on posedge
//  reset_n     in   1         asynchronous, active-low reset
//  run         in   1         level: 1 = sequence, 0 = stop/hold
//  mode        in   2         00 rot-left, 01 rot-right, 10 bounce, 11 invert
//  pattern_ld  in   1         one-cycle pulse: load pattern_in into shift reg
//  pattern_in  in   LED_W     seed pattern
//  step_req    in   1         single-step request (HOLD only), 4-phase
//  step_ack    out  1         single-step acknowledge
//  tick        out  1         one-cycle pulse at each prescaler wrap
//  state       out  2         00 IDLE, 01 RUN, 10 HOLD
//  led         out  LED_W     LED drive
//  duty        in   PWM_BITS  brightness (LED_PWM_EN only)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-step): sr=1 (LSB set), dir=left, prescaler=0, state=IDLE,
//    led=0, tick=0, step_ack=0. Outputs registered; all take effect the edge after the cause.
//  - FSM: IDLE->RUN when run=1 (if sr==0, sr loads 1). RUN->HOLD when run=0. HOLD->RUN when run=1.
//    Only reset returns to IDLE. led=0 in IDLE, led=sr in RUN/HOLD.
//  - Prescaler counts only in RUN, 0..TICK_DIV-1, wraps to 0; tick=1 for the cycle after count
//    reaches TICK_DIV-1. Frozen (not cleared) in HOLD; cleared on pattern_ld.
//  - Step op on tick (RUN) or accepted step (HOLD), using mode sampled that cycle:
//    rot-left {sr[W-2:0],sr[W-1]}; rot-right {sr[0],sr[W-1:1]}; invert ~sr;
//    bounce: if dir=left and sr[W-1]=1 -> dir=right, shift right this step; if dir=right and sr[0]=1
//    -> dir=left, shift left; otherwise shift (non-rotating) in dir. dir persists across modes.
//  - pattern_ld (any state except IDLE, also IDLE): sr<=pattern_in, dir<=left, prescaler<=0.
//    Load beats a coincident tick/step: tick still pulses, op suppressed. pattern_in=0 is legal
//    (all ops except invert keep 0).
//  - Handshake: in HOLD, step_req=1 & step_ack=0 -> apply one op, step_ack=1 next cycle, held
//    until step_req=0, then step_ack=0 next cycle. step_req ignored in IDLE/RUN. If run rises while
//    step_ack=1, state->RUN and step_ack still drops only after step_req=0.
//  - run falling the same cycle as a tick: op applied, then HOLD.
// CONFIGURATION
//  LED_PWM_EN defined: duty port present; free-running PWM_BITS counter pc (reset 0, all states);
//    led = sr & {LED_W{pc < duty}}; duty=0 -> dark; duty=max -> on (2^PWM_BITS-1)/2^PWM_BITS.
//  LED_PWM_EN undefined: no duty port, no PWM counter, led = sr (full on).
// TESTING (CLK_HZ=8, STEP_HZ=1 -> TICK_DIV=8, LED_W=4)
//  1. Reset, run=1, mode=00 -> state=01; tick every 8 clk; led 0001,0010,0100,1000,0001.
//  2. mode=10, load 0001, run 10 ticks -> led 0001,0010,0100,1000,0100,0010,0001,0010,...
//  3. run=0 mid-count -> state=10, led/prescaler frozen; step_req=1 -> one rotate, step_ack=1
//     until step_req=0; run=1 -> ticks resume from frozen count.
//  4. pattern_ld with pattern_in=1010 on a tick cycle, mode=11 -> led=1010, no invert;
//     next tick 8 clk later -> 0101.
//  5. reset_n low mid-RUN for a partial cycle -> led=0, state=00, tick=0, step_ack=0 immediately.
//  6. LED_PWM_EN, PWM_BITS=4, duty=4, led pattern 0001 -> bit0 high 4 of every 16 clk; duty=0 -> always 0.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: LED pattern sequencer with a prescaled step tick, an IDLE/RUN/HOLD FSM,
// selectable pattern operations and a 4-phase single-step handshake while held.
// Optional feature macro: LED_PWM_EN. When it is defined, the module adds a duty port and a
// free-running PWM counter that gates the LED drive.

// Combinational step operation applied to the shift register.
module led_seq_op #(
  parameter int LED_W = 4
) (
  input  logic [LED_W-1:0] sr,
  input  logic             dir,     // 0 = left, 1 = right
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] sr_o,
  output logic             dir_o
);

  // Pattern operation for the mode sampled this cycle.
  always_comb begin
    sr_o  = sr;
    dir_o = dir;
    case (mode)
      2'b00: sr_o = {sr[LED_W-2:0], sr[LED_W-1]};
      2'b01: sr_o = {sr[0], sr[LED_W-1:1]};
      2'b10: begin
        // Bounce turns around when the lit edge bit is reached, moving away in the same step.
        if (!dir && sr[LED_W-1]) begin
          dir_o = 1'b1;
          sr_o  = sr >> 1;
        end else if (dir && sr[0]) begin
          dir_o = 1'b0;
          sr_o  = sr << 1;
        end else if (dir) begin
          sr_o = sr >> 1;
        end else begin
          sr_o = sr << 1;
        end
      end
      default: sr_o = ~sr;
    endcase
  end

endmodule

module led_seq_ctrl #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int STEP_HZ  = 1,
  parameter int LED_W    = 4,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [1:0]          mode,
  input  logic                pattern_ld,
  input  logic [LED_W-1:0]    pattern_in,
  input  logic                step_req,
  output logic                step_ack,
  output logic                tick,
  output logic [1:0]          state,
  output logic [LED_W-1:0]    led
`ifdef LED_PWM_EN
  ,
  input  logic [PWM_BITS-1:0] duty
`endif
);

  localparam int TICK_DIV = CLK_HZ / STEP_HZ;
  localparam int CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t           st_q, st_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [LED_W-1:0] sr_q, sr_n, op_sr;
  logic             dir_q, dir_n, op_dir;
  logic             tick_n, ack_n;
  logic [LED_W-1:0] led_n;
  logic             wrap, step_go, do_op, pwm_on;

  led_seq_op #(.LED_W(LED_W)) u_op (
    .sr    (sr_q),
    .dir   (dir_q),
    .mode  (mode),
    .sr_o  (op_sr),
    .dir_o (op_dir)
  );

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pc;

  // Free-running PWM phase counter, independent of FSM state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= '0;
    else          pc <= pc + 1'b1;
  end

  assign pwm_on = (pc < duty);
`else
  assign pwm_on = 1'b1;
`endif

  // Next-state, prescaler, pattern and handshake decode.
  always_comb begin
    st_n    = st_q;
    cnt_n   = cnt_q;
    sr_n    = sr_q;
    dir_n   = dir_q;
    wrap    = (st_q == RUN) && (cnt_q == CNT_LAST);
    step_go = (st_q == HOLD) && step_req && !step_ack;
    do_op   = (wrap || step_go) && !pattern_ld;

    case (st_q)
      IDLE:    if (run)  st_n = RUN;
      RUN:     if (!run) st_n = HOLD;
      HOLD:    if (run)  st_n = RUN;
      default: st_n = IDLE;
    endcase

    // Prescaler advances only in RUN; HOLD leaves it where it stopped.
    if (pattern_ld)        cnt_n = '0;
    else if (st_q == RUN)  cnt_n = wrap ? '0 : cnt_q + 1'b1;

    // A load wins over a coincident step; leaving IDLE with an empty pattern seeds one lit LED.
    if (pattern_ld) begin
      sr_n  = pattern_in;
      dir_n = 1'b0;
    end else if (do_op) begin
      sr_n  = op_sr;
      dir_n = op_dir;
    end else if (st_q == IDLE && run && sr_q == '0) begin
      sr_n = LED_W'(1);
    end

    tick_n = wrap;
    // Once acknowledged, ack simply follows the request until it drops, whatever the state.
    ack_n  = step_ack ? step_req : step_go;
    led_n  = (st_n == IDLE) ? '0 : (sr_n & {LED_W{pwm_on}});
  end

  // State, pattern and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q     <= IDLE;
      cnt_q    <= '0;
      sr_q     <= LED_W'(1);
      dir_q    <= 1'b0;
      tick     <= 1'b0;
      step_ack <= 1'b0;
      led      <= '0;
    end else begin
      st_q     <= st_n;
      cnt_q    <= cnt_n;
      sr_q     <= sr_n;
      dir_q    <= dir_n;
      tick     <= tick_n;
      step_ack <= ack_n;
      led      <= led_n;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_DIV=8, LED_W=4. Vectors hold inputs for a number
// of clocks, then check state/led/tick/step_ack.
module tb_led_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       pattern_ld = 1'b0;
  logic [3:0] pattern_in = 4'b0;
  logic       step_req = 1'b0;
  logic       step_ack, tick;
  logic [1:0] state;
  logic [3:0] led;
`ifdef LED_PWM_EN
  logic [3:0] duty = 4'd0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  led_seq_ctrl #(.CLK_HZ(8), .STEP_HZ(1), .LED_W(4), .PWM_BITS(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .mode       (mode),
    .pattern_ld (pattern_ld),
    .pattern_in (pattern_in),
    .step_req   (step_req),
    .step_ack   (step_ack),
    .tick       (tick),
    .state      (state),
    .led        (led)
`ifdef LED_PWM_EN
    ,
    .duty       (duty)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       run;
    logic [1:0] mode;
    logic       ld;
    logic [3:0] pin;
    logic       req;
    logic [1:0] st;
    logic [3:0] led;
    logic       tk;
    logic       ack;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int cyc, input logic r, input logic [1:0] m, input logic ld,
                     input logic [3:0] pin, input logic req, input logic [1:0] st,
                     input logic [3:0] l, input logic tk, input logic ack);
    vec_t v;
    v.cyc = cyc; v.run = r; v.mode = m; v.ld = ld; v.pin = pin; v.req = req;
    v.st = st; v.led = l; v.tk = tk; v.ack = ack;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one vector (load is a single-cycle pulse), hold it, then compare outputs.
  task automatic apply(input vec_t v, input string tag);
    run = v.run; mode = v.mode; pattern_in = v.pin; step_req = v.req; pattern_ld = v.ld;
    clks(1);
    pattern_ld = 1'b0;
    if (v.cyc > 1) clks(v.cyc - 1);
    chk({tag, " state"}, {6'b0, state}, {6'b0, v.st});
    chk({tag, " led"},   {4'b0, led},   {4'b0, v.led});
    chk({tag, " tick"},  {7'b0, tick},  {7'b0, v.tk});
    chk({tag, " ack"},   {7'b0, step_ack}, {7'b0, v.ack});
  endtask

  initial begin
    #12;
    chk("reset state", {6'b0, state}, 8'd0);
    chk("reset led",   {4'b0, led},   8'd0);
    chk("reset tick",  {7'b0, tick},  8'd0);
    chk("reset ack",   {7'b0, step_ack}, 8'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

`ifndef LED_PWM_EN
    // rotate left from reset seed
    add(1,1,0,0,4'b0000,0, 1,4'b0001,0,0);
    add(7,1,0,0,4'b0000,0, 1,4'b0001,0,0);
    add(1,1,0,0,4'b0000,0, 1,4'b0010,1,0);
    add(1,1,0,0,4'b0000,0, 1,4'b0010,0,0);
    add(7,1,0,0,4'b0000,0, 1,4'b0100,1,0);
    add(8,1,0,0,4'b0000,0, 1,4'b1000,1,0);
    add(8,1,0,0,4'b0000,0, 1,4'b0001,1,0);
    // bounce after a load of 0001
    add(8,1,2,1,4'b0001,0, 1,4'b0001,0,0);
    add(1,1,2,0,4'b0000,0, 1,4'b0010,1,0);
    add(8,1,2,0,4'b0000,0, 1,4'b0100,1,0);
    add(8,1,2,0,4'b0000,0, 1,4'b1000,1,0);
    add(8,1,2,0,4'b0000,0, 1,4'b0100,1,0);
    add(8,1,2,0,4'b0000,0, 1,4'b0010,1,0);
    add(8,1,2,0,4'b0000,0, 1,4'b0001,1,0);
    add(8,1,2,0,4'b0000,0, 1,4'b0010,1,0);
    // hold mid-count, single step, resume from frozen count
    add(3,1,0,0,4'b0000,0, 1,4'b0010,0,0);
    add(1,0,0,0,4'b0000,0, 2,4'b0010,0,0);
    add(5,0,0,0,4'b0000,0, 2,4'b0010,0,0);
    add(1,0,0,0,4'b0000,1, 2,4'b0100,0,1);
    add(3,0,0,0,4'b0000,1, 2,4'b0100,0,1);
    add(1,0,0,0,4'b0000,0, 2,4'b0100,0,0);
    add(1,1,0,0,4'b0000,0, 1,4'b0100,0,0);
    add(3,1,0,0,4'b0000,0, 1,4'b0100,0,0);
    add(1,1,0,0,4'b0000,0, 1,4'b1000,1,0);
    // load on a tick cycle suppresses invert
    add(7,1,3,0,4'b0000,0, 1,4'b1000,0,0);
    add(1,1,3,1,4'b1010,0, 1,4'b1010,1,0);
    add(8,1,3,0,4'b0000,0, 1,4'b0101,1,0);
    add(8,1,3,0,4'b0000,0, 1,4'b1010,1,0);
    // run falls on the tick cycle: op applied, then HOLD
    add(7,1,3,0,4'b0000,0, 1,4'b1010,0,0);
    add(1,0,3,0,4'b0000,0, 2,4'b0101,1,0);
    add(1,0,3,0,4'b0000,0, 2,4'b0101,0,0);
    // run rises while acknowledged; request ignored in RUN
    add(1,0,0,0,4'b0000,1, 2,4'b1010,0,1);
    add(1,1,0,0,4'b0000,1, 1,4'b1010,0,1);
    add(2,1,0,0,4'b0000,1, 1,4'b1010,0,1);
    add(1,1,0,0,4'b0000,0, 1,4'b1010,0,0);
    add(1,1,0,0,4'b0000,1, 1,4'b1010,0,0);
    add(3,1,0,0,4'b0000,0, 1,4'b1010,0,0);
    add(1,1,0,0,4'b0000,0, 1,4'b0101,1,0);
    // zero pattern: rotate keeps 0, invert gives all on
    add(8,1,0,1,4'b0000,0, 1,4'b0000,0,0);
    add(1,1,0,0,4'b0000,0, 1,4'b0000,1,0);
    add(8,1,3,0,4'b0000,0, 1,4'b1111,1,0);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("v%0d", i));

    // asynchronous reset while tick is high mid-RUN
    #2 reset_n = 1'b0;
    #1;
    chk("async rst state", {6'b0, state}, 8'd0);
    chk("async rst led",   {4'b0, led},   8'd0);
    chk("async rst tick",  {7'b0, tick},  8'd0);
    chk("async rst ack",   {7'b0, step_ack}, 8'd0);
    run = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    vq.delete();
    add(1,0,0,1,4'b0000,0, 0,4'b0000,0,0);   // load 0 in IDLE
    add(1,1,0,0,4'b0000,0, 1,4'b0001,0,0);   // leaving IDLE with sr=0 seeds 1
    add(7,1,0,0,4'b0000,0, 1,4'b0001,0,0);
    add(1,1,0,0,4'b0000,0, 1,4'b0010,1,0);
    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("p%0d", i));
`else
    // PWM: park in HOLD with sr=0001 and measure the on-time of bit 0 over one PWM period
    begin
      int on_cnt;
      duty = 4'd4;
      run = 1'b1; clks(1);
      run = 1'b0; clks(2);
      chk("pwm hold state", {6'b0, state}, 8'd2);
      on_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        if (led[0]) on_cnt++;
        clks(1);
      end
      chk("pwm duty4 on", 8'(on_cnt), 8'd4);
      duty = 4'd0; clks(2);
      on_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        if (led[0]) on_cnt++;
        clks(1);
      end
      chk("pwm duty0 on", 8'(on_cnt), 8'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
